alu_issue_ctrl: RTL and testbench

- Multi-cycle issue/sequencing controller that drives the combinational ALU's opcode/A/B inputs and consumes its 32-bit result.
- Accepts one instruction word per valid/ready handshake and reads operands from an internal 32x32 register file.
- Issues the operation, samples the ALU result, writes back, and maintains Z/N flags.
- Sits between instruction fetch and the ALU in the processor datapath.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states, instruction fields and legality check for alu_issue_ctrl
package alu_pkg;

  // Arithmetic / shift opcodes
  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_ADDINC = 5'b00001;
  localparam logic [4:0] OP_INCA   = 5'b00011;
  localparam logic [4:0] OP_SUBDEC = 5'b00100;
  localparam logic [4:0] OP_SUB    = 5'b00101;
  localparam logic [4:0] OP_DECA   = 5'b00110;
  localparam logic [4:0] OP_LSL    = 5'b01000;
  localparam logic [4:0] OP_ASR    = 5'b01001;

  // Bitwise opcodes: the whole 1xxxx range is a lookup of the two operand bits
  localparam logic [4:0] OP_ZEROS  = 5'b10000;
  localparam logic [4:0] OP_AND    = 5'b10001;
  localparam logic [4:0] OP_PASSB  = 5'b10011;
  localparam logic [4:0] OP_XOR    = 5'b10110;
  localparam logic [4:0] OP_OR     = 5'b10111;
  localparam logic [4:0] OP_ONES   = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPRD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Instruction word field positions
  localparam int F_OP_LSB  = 27;
  localparam int F_RD_LSB  = 22;
  localparam int F_RS_LSB  = 17;
  localparam int F_IMM_SEL = 16;
  localparam int F_RT_LSB  = 11;
  localparam int F_IMM_LSB = 0;

  function automatic logic is_legal_op(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    if (op[4]) begin
      ok = 1'b1;
    end else begin
      case (op)
        OP_ADD, OP_ADDINC, OP_INCA, OP_SUBDEC,
        OP_SUB, OP_DECA, OP_LSL, OP_ASR: ok = 1'b1;
        default:                          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with two operand read ports, a debug read port and one write port; R0 reads zero
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREGS = 1 << REG_AW;

  logic [DATA_W-1:0] mem [NREGS];

  // Storage: cleared on reset; writes to R0 are discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == '0)      ? '0 : mem[ra1];
  assign rd2      = (ra2 == '0)      ? '0 : mem[ra2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/sequencing controller for the combinational ALU; optional sticky trap via ALU_ILLEGAL_TRAP_EN
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int EXEC_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              done,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [7:0] WAIT_LAST = 8'(EXEC_WAIT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       instr_q;
  logic [4:0]        alu_op_d;
  logic              accept;
  logic              exec_last;
  logic              trap_q;

  logic [4:0]        op_q;
  logic [REG_AW-1:0] rd_q, rs_q, rt_q;
  logic              imm_sel_q;
  logic [15:0]       imm_q;
  logic              legal_q;
  logic [DATA_W-1:0] rs_data, rt_data, imm_ext;

  assign op_q      = instr_q[F_OP_LSB +: 5];
  assign rd_q      = instr_q[F_RD_LSB +: REG_AW];
  assign rs_q      = instr_q[F_RS_LSB +: REG_AW];
  assign rt_q      = instr_q[F_RT_LSB +: REG_AW];
  assign imm_sel_q = instr_q[F_IMM_SEL];
  assign imm_q     = instr_q[F_IMM_LSB +: 16];
  assign imm_ext   = {{(DATA_W-16){imm_q[15]}}, imm_q};
  assign legal_q   = is_legal_op(op_q);

  assign instr_ready = (state_q == S_IDLE) && !trap_q;

`ifdef ALU_ILLEGAL_TRAP_EN
  // Sticky trap: once an undefined op retires, stop accepting until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (exec_last && !legal_q) begin
      trap_q <= 1'b1;
    end
  end
`else
  assign trap_q = 1'b0;
`endif

  // State register and EXEC hold counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; alu_op is parked at ZEROS outside EXEC so every issue toggles it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    exec_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          accept  = 1'b1;
          state_d = S_OPRD;
        end
      end
      S_OPRD: begin
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_q == WAIT_LAST) begin
          exec_last = 1'b1;
          state_d   = S_WB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    alu_op_d = (state_d == S_EXEC) ? op_q : OP_ZEROS;
  end

  // Datapath: ALU drive registers, result capture at the end of EXEC, done/illegal pulse during WB.
  // The result is taken while the opcode is still applied, so the write and flags are already
  // visible in the cycle that done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      alu_op  <= OP_ZEROS;
      alu_a   <= '0;
      alu_b   <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      alu_op  <= alu_op_d;
      done    <= exec_last;
      illegal <= exec_last && !legal_q;
      if (accept) begin
        instr_q <= instr;
      end
      if (state_q == S_OPRD) begin
        alu_a <= rs_data;
        alu_b <= imm_sel_q ? imm_ext : rt_data;
      end
      if (exec_last && legal_q) begin
        flag_z <= (alu_out == '0);
        flag_n <= alu_out[DATA_W-1];
      end
    end
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ra1      (rs_q),
    .rd1      (rs_data),
    .ra2      (rt_q),
    .rd2      (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (exec_last && legal_q),
    .wa       (rd_q),
    .wd       (alu_out)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with an ALU stub and a reference model
module tb_alu_issue_ctrl;

  localparam int EW = 1;
`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [4:0] ZEROS = 5'b10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        flag_z, flag_n, done, illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mr [32];
  logic        mz, mn, mtrap;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .DATA_W    (32),
    .REG_AW    (5),
    .EXEC_WAIT (EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .done        (done),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [3:0]  lut;
    r = 32'hDEAD_BEEF;
    if (op[4]) begin
      lut = op[3:0];
      for (int i = 0; i < 32; i++) r[i] = lut[{~b[i], ~a[i]}];
    end else begin
      case (op)
        5'd0: r = a + b;
        5'd1: r = a + b + 32'd1;
        5'd3: r = a + 32'd1;
        5'd4: r = a - b - 32'd1;
        5'd5: r = a - b;
        5'd6: r = a - 32'd1;
        5'd8: r = a << b[4:0];
        5'd9: r = 32'($signed(a) >>> b[4:0]);
        default: r = 32'hDEAD_BEEF;
      endcase
    end
    return r;
  endfunction

  function automatic logic spec_legal(input logic [4:0] op);
    return (op >= 5'd16) || (op inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9});
  endfunction

  always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic dbg_rd(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mr[i] = 32'd0;
    mz = 1'b0;
    mn = 1'b0;
    mtrap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic isel, input logic [15:0] lo);
    logic [31:0] a, b, res, d;
    logic        legal;
    int          cyc, guard;
    a     = mr[rs];
    b     = isel ? {{16{lo[15]}}, lo} : mr[lo[15:11]];
    res   = alu_fn(op, a, b);
    legal = spec_legal(op);
    instr = {op, rd, rs, isel, lo};
    instr_valid = 1'b1;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", 32'(guard < 50), 32'd1);
    if (guard >= 50) begin
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    instr = $urandom;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      chk((cyc == 1) ? "alu_op_oprd" : "alu_op_exec", 32'(alu_op),
          32'((cyc >= 2 && cyc <= 1 + EW) ? op : ZEROS));
      if (cyc == 2) begin
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    chk("done_latency", 32'(cyc), 32'(2 + EW));
    chk("illegal", 32'(illegal), 32'(!legal));
    chk("alu_op_wb", 32'(alu_op), 32'(ZEROS));
    chk("ready_wb", 32'(instr_ready), 32'd0);
    if (legal) begin
      if (rd != 5'd0) mr[rd] = res;
      mz = (res == 32'd0);
      mn = res[31];
    end else begin
      mtrap = mtrap | TRAP;
    end
    chk("flag_z", 32'(flag_z), 32'(mz));
    chk("flag_n", 32'(flag_n), 32'(mn));
    dbg_rd(rd, d);
    chk("reg_rd", d, mr[rd]);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_after", 32'(instr_ready), 32'(!mtrap));
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  op, rd, rs;
    logic        isel;
    logic [15:0] lo;

    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    dbg_addr = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_alu_op", 32'(alu_op), 32'(ZEROS));
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_flag_z", 32'(flag_z), 32'd0);
    chk("rst_flag_n", 32'(flag_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      dbg_rd(5'(i), d);
      chk("rst_reg", d, 32'd0);
    end

    // Directed sequence
    issue(5'b10011, 5'd1, 5'd0, 1'b1, 16'd5);
    dbg_rd(5'd1, d); chk("r1_is_5", d, 32'd5);
    chk("z_after_passb", 32'(flag_z), 32'd0);
    issue(5'b00101, 5'd2, 5'd1, 1'b0, {5'd1, 11'd0});
    dbg_rd(5'd2, d); chk("r2_is_0", d, 32'd0);
    chk("z_after_sub", 32'(flag_z), 32'd1);
    issue(5'b00000, 5'd3, 5'd1, 1'b1, 16'd7);
    dbg_rd(5'd3, d); chk("r3_is_12", d, 32'd12);
    issue(5'b00000, 5'd3, 5'd3, 1'b1, 16'd7);
    dbg_rd(5'd3, d); chk("r3_is_19", d, 32'd19);
    issue(5'b00000, 5'd0, 5'd1, 1'b1, 16'd1);
    dbg_rd(5'd0, d); chk("r0_is_0", d, 32'd0);
    chk("z_after_r0", 32'(flag_z), 32'd0);
    chk("n_after_r0", 32'(flag_n), 32'd0);
    issue(5'b10011, 5'd4, 5'd0, 1'b1, 16'hFFFF);
    dbg_rd(5'd4, d); chk("r4_sext", d, 32'hFFFF_FFFF);
    chk("n_after_sext", 32'(flag_n), 32'd1);
    issue(5'b01001, 5'd5, 5'd4, 1'b1, 16'd3);
    dbg_rd(5'd5, d); chk("r5_asr", d, 32'hFFFF_FFFF);

    // Undefined op: no write, flags held
    issue(5'b00010, 5'd6, 5'd1, 1'b1, 16'd9);
    dbg_rd(5'd6, d); chk("r6_untouched", d, 32'd0);
    chk("n_held", 32'(flag_n), 32'd1);
    for (int i = 0; i < 6; i++) begin
      instr = {5'b10011, 5'd7, 5'd0, 1'b1, 16'd1};
      instr_valid = mtrap;
      chk("ready_hold", 32'(instr_ready), 32'(!mtrap));
      @(negedge clk);
    end
    instr_valid = 1'b0;
    do_reset();
    chk("ready_post_reset", 32'(instr_ready), 32'd1);

    // Randomized instructions
    for (int k = 0; k < 60; k++) begin
      op   = 5'($urandom_range(0, 31));
      if (TRAP && !spec_legal(op)) op = 5'b10011;
      rd   = 5'($urandom);
      rs   = 5'($urandom);
      isel = 1'($urandom);
      lo   = 16'($urandom);
      issue(op, rd, rs, isel, lo);
    end

    // Reset during EXEC aborts without writeback
    instr = {5'b10011, 5'd7, 5'd0, 1'b1, 16'h1234};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_op", 32'(alu_op), 32'h13);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_done_after", 32'(done), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_alu_op", 32'(alu_op), 32'(ZEROS));
    dbg_rd(5'd7, d); chk("abort_r7", d, 32'd0);
    issue(5'b00011, 5'd8, 5'd0, 1'b1, 16'd0);
    dbg_rd(5'd8, d); chk("r8_inca", d, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
